// File: rtl/alu_pkg.sv
// Shared ALU select codes and multiplier state encoding.
// The ALU control decoder uses the same op-code values.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Signed shift-add multiplier: operates on magnitudes for WIDTH iterations,
// then fixes the sign of the 2*WIDTH product in a final cycle.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mul_state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic               sign;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     upper_sum;

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = MUL;
      MUL:  if (count == CNT_W'(WIDTH-1)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      count <= '0;
      sign  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= abs_a;
            acc   <= {{WIDTH{1'b0}}, abs_b};
            count <= '0;
            sign  <= a[WIDTH-1] ^ b[WIDTH-1];
          end
        end
        MUL: begin
          acc   <= {upper_sum, acc[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // done marks the FIN cycle; the parent registers product on that edge.
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign product = sign ? (~acc + 1'b1) : acc;

endmodule

// File: rtl/alu_exec.sv
// EX-stage ALU: single-cycle logic/arith ops plus a multi-cycle signed MUL,
// with a start/done handshake and registered result and flags.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   op_result;
  logic               op_ovf;
  logic               op_err;

  assign accept    = start && !mul_busy;
  assign mul_start = accept && (alu_sel == ALU_MUL);
  assign busy      = mul_busy;

  alu_mul_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    op_result = '0;
    op_ovf    = 1'b0;
    op_err    = 1'b0;
    case (alu_sel)
      ALU_AND: op_result = a & b;
      ALU_OR:  op_result = a | b;
      ALU_ADD: begin
        op_result = sum;
        op_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        op_result = diff;
        op_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_MUL: op_result = '0;
      default: op_err = 1'b1;
    endcase
  end

  // A MUL completion and a new accept never coincide: FIN holds busy high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mul_done) begin
        done      <= 1'b1;
        result    <= mul_product[WIDTH-1:0];
        result_hi <= mul_product[2*WIDTH-1:WIDTH];
        zero      <= (mul_product[WIDTH-1:0] == '0);
        ovf       <= 1'b0;
        err       <= 1'b0;
      end else if (accept && (alu_sel != ALU_MUL)) begin
        done      <= 1'b1;
        result    <= op_result;
        result_hi <= '0;
        zero      <= (op_result == '0);
        ovf       <= op_ovf;
        err       <= op_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expectations.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;
  logic             err;

  int checkCount = 0;
  int failCount  = 0;
  int edges;
  int busyHigh;

  alu_exec #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_sel   (alu_sel),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request for exactly one rising edge; returns #1 after it.
  task automatic applyStimulus(input logic [3:0] sel, input logic [WIDTH-1:0] opa,
                               input logic [WIDTH-1:0] opb);
    @(negedge clk);
    start   = 1'b1;
    alu_sel = sel;
    a       = opa;
    b       = opb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done with a cycle bound; optionally pokes start mid-operation.
  task automatic waitDone(input bit poke, output int nEdges, output int nBusy);
    nEdges = 0;
    nBusy  = busy ? 1 : 0;
    while (!done && nEdges < 100) begin
      if (poke && nEdges == 5) begin
        start   = 1'b1;
        alu_sel = ALU_ADD;
        a       = 32'd1;
        b       = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      nEdges++;
      if (busy) nBusy++;
      if (poke && nEdges > 1 && !done) checkOutput("hold_while_busy", {32'd0, result}, 64'h0000_00F0);
    end
    checkOutput("mul_done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_sel = 4'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy",   {63'd0, busy}, 64'd0);
    checkOutput("rst_done",   {63'd0, done}, 64'd0);
    checkOutput("rst_result", {result_hi, result}, 64'd0);
    checkOutput("rst_flags",  {61'd0, zero, ovf, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(ALU_ADD, 32'd7, 32'd5);
    checkOutput("add_done",   {63'd0, done}, 64'd1);
    checkOutput("add_result", {result_hi, result}, 64'd12);
    checkOutput("add_flags",  {61'd0, zero, ovf, err}, 64'd0);
    checkOutput("add_busy",   {63'd0, busy}, 64'd0);

    applyStimulus(ALU_SUB, 32'h8000_0000, 32'd1);
    checkOutput("sub_done",   {63'd0, done}, 64'd1);
    checkOutput("sub_result", {32'd0, result}, 64'h7FFF_FFFF);
    checkOutput("sub_ovf",    {63'd0, ovf}, 64'd1);
    applyStimulus(ALU_SLT, 32'hFFFF_FFFD, 32'd2);
    checkOutput("slt_done",   {63'd0, done}, 64'd1);
    checkOutput("slt_result", {32'd0, result}, 64'd1);
    checkOutput("slt_ovf",    {63'd0, ovf}, 64'd0);
    applyStimulus(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0);
    checkOutput("and_done",   {63'd0, done}, 64'd1);
    checkOutput("and_result", {32'd0, result}, 64'h0000_00F0);
    @(posedge clk);
    #1;
    checkOutput("idle_done",  {63'd0, done}, 64'd0);

    applyStimulus(ALU_MUL, 32'hFFFF_FFFA, 32'd7);
    checkOutput("mul_busy_start", {63'd0, busy}, 64'd1);
    checkOutput("mul_done_start", {63'd0, done}, 64'd0);
    waitDone(1'b1, edges, busyHigh);
    checkOutput("mul_latency",  64'(edges), 64'd33);
    checkOutput("mul_busy_len", 64'(busyHigh), 64'd33);
    checkOutput("mul_product",  {result_hi, result}, 64'hFFFF_FFFF_FFFF_FFD6);
    checkOutput("mul_flags",    {61'd0, zero, ovf, err}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("mul_single_done", {63'd0, done}, 64'd0);

    applyStimulus(ALU_MUL, 32'h8000_0000, 32'h8000_0000);
    waitDone(1'b0, edges, busyHigh);
    checkOutput("mulneg_latency", 64'(edges), 64'd33);
    checkOutput("mulneg_product", {result_hi, result}, 64'h4000_0000_0000_0000);
    checkOutput("mulneg_zero",    {63'd0, zero}, 64'd1);
    checkOutput("mulneg_busy",    {63'd0, busy}, 64'd0);
    applyStimulus(ALU_SUB, 32'd10, 32'd3);
    checkOutput("sub_in_done_cycle", {63'd0, done}, 64'd1);
    checkOutput("sub_after_mul",     {result_hi, result}, 64'd7);
    checkOutput("sub_after_zero",    {63'd0, zero}, 64'd0);

    applyStimulus(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    checkOutput("ill_done",   {63'd0, done}, 64'd1);
    checkOutput("ill_err",    {63'd0, err}, 64'd1);
    checkOutput("ill_result", {result_hi, result}, 64'd0);
    checkOutput("ill_zero",   {63'd0, zero}, 64'd1);
    applyStimulus(ALU_OR, 32'h0000_000F, 32'h0000_00F0);
    checkOutput("or_err",    {63'd0, err}, 64'd0);
    checkOutput("or_result", {32'd0, result}, 64'h0000_00FF);
    checkOutput("or_zero",   {63'd0, zero}, 64'd0);

    applyStimulus(ALU_MUL, 32'd3, 32'd4);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy",   {63'd0, busy}, 64'd0);
    checkOutput("midrst_done",   {63'd0, done}, 64'd0);
    checkOutput("midrst_result", {result_hi, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) checkOutput("midrst_no_done", {63'd0, done}, 64'd0);
    end
    checkOutput("midrst_idle_busy", {63'd0, busy}, 64'd0);
    applyStimulus(ALU_ADD, 32'd1, 32'd1);
    checkOutput("add_after_rst", {result_hi, result}, 64'd2);
    checkOutput("add_after_rst_done", {63'd0, done}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution-side consumer of the 4-bit ALU select code produced by the ALU control decoder.
- Performs the selected operation on two operands with a start/done handshake.
- AND, OR, ADD, SUB and SLT complete in one cycle. MUL is a multi-cycle signed shift-add unit.
- Sits in the EX stage between the register-read operand muxes and the write-back mux.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- alu_sel  in  4  operation code, latched on acceptance.
- a  in  WIDTH  operand A, latched on acceptance.
- b  in  WIDTH  operand B, latched on acceptance.
- busy  out  1  a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  WIDTH  low word of the result.
- result_hi  out  WIDTH  high word of the MUL product; 0 for all other ops.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow, ADD/SUB only.
- err  out  1  illegal alu_sel.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, done, result, result_hi, zero, ovf, err, counter and accumulator all 0.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 SLT, signed: result = {0..,1} if $signed(a) < $signed(b), else 0.
  - 0011 MUL, signed, WIDTH x WIDTH -> 2*WIDTH.
  - Any other code is illegal.
- Acceptance: on a rising edge with start=1 and busy=0. start while busy=1 is ignored; it is neither queued nor erroring.
- States:
  - IDLE: non-MUL start -> compute and register outputs on the accepting edge, done=1 for the next cycle, stay in IDLE. MUL start -> latch |a| and |b| and the sign (a[W-1]^b[W-1]), clear the accumulator, counter=0, busy=1, go to MUL.
  - MUL: each edge, if multiplier LSB=1 add multiplicand to the accumulator upper half, then shift right by 1. counter increments. After WIDTH iterations go to FIN.
  - FIN: one edge. Apply two's-complement negate of the 2*WIDTH product if sign=1. Register result, result_hi and zero. done=1, busy=0, go to IDLE.
- Latency, measured from the accepting edge to the edge that makes done visible:
  - Non-MUL: 1 edge. Throughput is one op per cycle (back-to-back starts are legal).
  - MUL: WIDTH+1 edges. busy is high for WIDTH+1 cycles.
- done is high exactly one cycle per accepted op. busy=0 during the done cycle, so a new start in that cycle is accepted.
- Output hold: result, result_hi and flags hold their value until the next completion. They do not change while busy.
- Flags:
  - zero: reflects result only; result_hi is ignored.
  - ovf: ADD sets it when operand signs are equal and result sign differs; SUB when operand signs differ and result sign differs from a. ovf=0 for all other ops.
  - The result is wrap-around regardless of ovf.
- Illegal code: 1-cycle latency. result=0, result_hi=0, zero=1, err=1, done=1. err=0 on every legal completion.
- Edge cases:
  - MUL with most-negative operand (e.g. 0x80000000): magnitude is taken as unsigned, so the product is still exact.
  - MUL by 0: full WIDTH+1 latency still applies; there is no early exit.
- Reset mid-MUL: state returns to IDLE immediately, with no done pulse and all outputs cleared.

Decomposition:
- Shared package (alu_pkg):
  - Op-code localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_MUL=4'b0011, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - State encoding IDLE/MUL/FIN.
  - These codes are the single source of truth shared with the ALU control decoder.
- One natural sub-module: alu_mul_seq, the signed shift-add multiplier with start/busy/done. alu_exec instantiates it and muxes its outputs.

Test Plan:
- Reset, then start ADD a=7 b=5 -> done next cycle, result=12, zero=0, ovf=0, err=0, busy never high.
- Back-to-back starts: SUB 0x80000000-1, then SLT -3,2, then AND 0xF0F0,0x0FF0 -> done on three consecutive cycles. Results:
  - SUB: 0x7FFFFFFF, ovf=1.
  - SLT: 1.
  - AND: 0x00F0.
- MUL a=-6 b=7 -> busy for 33 cycles, then done. {result_hi,result} = 64'hFFFFFFFF_FFFFFFD6. A start pulsed mid-operation is ignored.
- MUL a=0x80000000 b=0x80000000 -> result_hi=0x40000000, result=0, zero=1. A SUB started in the done cycle is accepted.
- alu_sel=4'b1111 -> done next cycle, err=1, result=0, zero=1. The next legal OR clears err.
- rst asserted at cycle 10 of a MUL -> outputs 0 immediately, no done. A later ADD 1+1 gives 2.
